// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its write-back path.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Register-address to one-hot select decoder, shared by the write-back and read paths.
module onehot_decoder #(
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    // Set exactly the bit selected by addr.
    always_comb begin
        onehot       = {NREG{1'b0}};
        onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and load sources, with a registered
// register-file write stage and a committed-write counter.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             s0_valid,
    input  logic [AW-1:0]    s0_addr,
    input  logic [WIDTH-1:0] s0_data,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [AW-1:0]    s1_addr,
    input  logic [WIDTH-1:0] s1_data,
    output logic             s1_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [NREG-1:0]  wb_sel,
    output logic             wb_we,
    output logic [15:0]      wr_count
);

    import regfile_pkg::*;

    logic             last_grant_r;
    logic             grant0_s;
    logic             grant1_s;
    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] data_s;
    logic [NREG-1:0]  sel_s;
    logic             load_s;
    logic [WIDTH-1:0] wb_data_r;
    logic [NREG-1:0]  wb_sel_r;
    logic             wb_we_r;
    logic [15:0]      wr_count_r;

    // Grant selection: on contention the source that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (hold) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (s0_valid && s1_valid) begin
            if (last_grant_r == SRC_ALU) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (s0_valid) begin
            grant0_s = 1'b1;
        end else if (s1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Winning request mux; a register-0 target is consumed without a write.
    always_comb begin
        addr_s = s0_addr;
        data_s = s0_data;
        if (grant1_s) begin
            addr_s = s1_addr;
            data_s = s1_data;
        end else begin
            addr_s = s0_addr;
            data_s = s0_data;
        end
        load_s = (grant0_s || grant1_s) && (addr_s != {AW{1'b0}});
    end

    assign s0_ready = grant0_s;
    assign s1_ready = grant1_s;

    onehot_decoder #(
        .AW   (AW),
        .NREG (NREG)
    ) u_sel_dec (
        .addr   (addr_s),
        .onehot (sel_s)
    );

    // Round-robin history; reset favours the ALU on the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= SRC_MEM;
        end else if (grant0_s) begin
            last_grant_r <= SRC_ALU;
        end else if (grant1_s) begin
            last_grant_r <= SRC_MEM;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Output write stage and commit counter; data holds when no write issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_r  <= {WIDTH{1'b0}};
            wb_sel_r   <= {NREG{1'b0}};
            wb_we_r    <= 1'b0;
            wr_count_r <= 16'd0;
        end else if (load_s) begin
            wb_data_r  <= data_s;
            wb_sel_r   <= sel_s;
            wb_we_r    <= 1'b1;
            wr_count_r <= wr_count_r + 16'd1;
        end else begin
            wb_sel_r   <= {NREG{1'b0}};
            wb_we_r    <= 1'b0;
        end
    end

    assign wb_data  = wb_data_r;
    assign wb_sel   = wb_sel_r;
    assign wb_we    = wb_we_r;
    assign wr_count = wr_count_r;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32-entry register file. Two write-back sources, ALU (source 0) and memory/load (source 1), compete for the single register-file write port. The block grants one source per cycle using round-robin, registers the winning write, and drives the register file's data, one-hot write-select and write-enable inputs. Writes to register 0 are discarded, and committed writes are counted for debug.

## Interface
Parameters:
- WIDTH, 32, data width of a register.
- NREG, 32, number of registers; one-hot select width.
- AW, 5, register address width; must satisfy 2**AW == NREG.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  when 1, no new grants are issued; an in-flight write still completes.
- s0_valid  input  1  ALU write request.
- s0_addr  input  AW  ALU destination register.
- s0_data  input  WIDTH  ALU write data.
- s0_ready  output  1  ALU request accepted this cycle; combinational.
- s1_valid  input  1  memory write request.
- s1_addr  input  AW  memory destination register.
- s1_data  input  WIDTH  memory write data.
- s1_ready  output  1  memory request accepted this cycle; combinational.
- wb_data  output  WIDTH  to register-file Rd.
- wb_sel  output  NREG  one-hot write select, to register-file CP_o.
- wb_we  output  1  write enable, to register-file RegWriteI.
- wr_count  output  16  number of committed (non-dropped) writes; wraps.

## Operation
- A request is accepted when sN_valid && sN_ready; the source holds addr and data stable until accepted.
- The grant is computed combinationally from s0_valid, s1_valid, hold and last_grant:
  - hold=1: both readys are 0.
  - Exactly one valid: that source is granted.
  - Both valid: the source that is not last_grant is granted.
- last_grant updates to the granted source only on an accepted request.
- An accepted request with addr==0 is consumed (ready=1), but nothing is loaded into the output stage: wb_we stays 0, wr_count is unchanged, last_grant still updates.
- An accepted request with addr!=0 loads the output stage on the next edge:
  - wb_data = data.
  - wb_sel = one-hot(addr).
  - wb_we = 1.
  - wr_count += 1, wrapping at 0xFFFF→0.
- If no non-zero write is accepted, the output stage shows wb_we=0 and wb_sel=0 on the next cycle; wb_data holds its last value.
- Reset values (asynchronous): wb_data=0, wb_sel=0, wb_we=0, wr_count=0, last_grant=1 (source 0 wins the first contention).

## Timing
- Acceptance in cycle N produces wb_we=1 with matching wb_sel/wb_data throughout cycle N+1. The register file captures at the end of N+1, so the value is visible on its Q output in cycle N+2.
- Throughput: one write per cycle. Back-to-back acceptances produce consecutive wb_we pulses with no bubble.
- hold asserted in cycle N:
  - No acceptance in N.
  - A write accepted in N-1 still issues in N.
- Reset mid-operation: the pending output write is cancelled immediately (wb_we drops asynchronously). No register is written, and the cancelled write is not counted.
- Invariants: wb_sel is one-hot whenever wb_we=1 and all-zero otherwise; wb_sel[0] is never 1.

## Structure
- Shared package regfile_pkg:
  - constants NREG=32, AW=5.
  - source ID constants SRC_ALU=0, SRC_MEM=1.
- Sub-module onehot_decoder (AW→NREG, combinational) generates wb_sel; it is reusable by the register-file read side.
- Everything else (arbiter, output register, counter) lives in this module.

## Test plan
- Reset: assert reset mid-stream with a write in the output stage → wb_we=0 and wr_count=0 immediately; after release, s0 wins the first contention.
- Single source: s0 writes addr=5, data=0xDEADBEEF in cycle N → cycle N+1 shows wb_we=1, wb_sel=0x00000020, wb_data=0xDEADBEEF; wr_count=1.
- Contention: both valid for 4 cycles (s0 addr=1, s1 addr=2) → grants alternate s0,s1,s0,s1; wb_sel sequence 0x2,0x4,0x2,0x4; wr_count=4.
- Zero register: s1 addr=0, data=0xFFFFFFFF → s1_ready=1, wb_we stays 0, wr_count unchanged; next contention grants s0.
- Hold: both valid with hold=1 for 3 cycles → both readys 0 and no wb_we pulse beyond the in-flight one; release → normal round-robin resumes.
- Counter wrap: preload to 0xFFFF via 65535 writes, one more write → wr_count=0x0000.
